// File: rtl/multdiv_hilo_ctrl_pkg.sv
// Shared types and constants for the MULT/DIV/HI-LO execute-stage controller.
package multdiv_hilo_ctrl_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = 6;

  typedef logic [WORD_W-1:0] word_t;

  // Decoded operations as seen in EX; only the multdiv and HI/LO moves act here.
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ALU   = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7
  } decoded_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } multdiv_state_t;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

endpackage

// File: rtl/multdiv_hilo_ctrl_div_radix2.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, sign fixup on the last step.
module multdiv_hilo_ctrl_div_radix2
  import multdiv_hilo_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  start_i,
  input  word_t a_i,
  input  word_t b_i,
  input  logic  signed_i,
  output logic  done_o,
  output word_t quo_o,
  output word_t rem_o
);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  word_t            prem_q;
  word_t            pquo_q;
  word_t            den_q;
  word_t            dvd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic             done_q;
  word_t            quo_q;
  word_t            rem_q;

  logic             a_neg_c;
  logic             b_neg_c;
  word_t            abs_a_c;
  word_t            abs_b_c;
  logic [WORD_W:0]  trial_c;
  logic             fits_c;
  word_t            prem_nxt_c;
  word_t            pquo_nxt_c;
  logic             last_c;
  word_t            quo_fix_c;
  word_t            rem_fix_c;

  // Operand magnitudes and sign flags captured at start.
  assign a_neg_c = signed_i & a_i[WORD_W-1];
  assign b_neg_c = signed_i & b_i[WORD_W-1];
  assign abs_a_c = a_neg_c ? (32'd0 - a_i) : a_i;
  assign abs_b_c = b_neg_c ? (32'd0 - b_i) : b_i;

  // One shift-subtract step; the dividend shifts out of pquo while quotient bits shift in.
  assign trial_c    = {prem_q, pquo_q[WORD_W-1]} - {1'b0, den_q};
  assign fits_c     = ~trial_c[WORD_W];
  assign prem_nxt_c = fits_c ? trial_c[WORD_W-1:0] : {prem_q[WORD_W-2:0], pquo_q[WORD_W-1]};
  assign pquo_nxt_c = {pquo_q[WORD_W-2:0], fits_c};
  assign last_c     = run_q && (cnt_q == CNT_W'(DIV_ITER - 1));

  // Sign fixup; divide by zero returns all-ones quotient and the raw dividend.
  assign quo_fix_c = dz_q      ? '1    :
                     neg_quo_q ? (32'd0 - pquo_nxt_c) : pquo_nxt_c;
  assign rem_fix_c = dz_q      ? dvd_q :
                     neg_rem_q ? (32'd0 - prem_nxt_c) : prem_nxt_c;

  // Iteration registers and final result capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      prem_q    <= '0;
      pquo_q    <= '0;
      den_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        run_q     <= 1'b1;
        cnt_q     <= '0;
        prem_q    <= '0;
        pquo_q    <= abs_a_c;
        den_q     <= abs_b_c;
        dvd_q     <= a_i;
        neg_quo_q <= a_neg_c ^ b_neg_c;
        neg_rem_q <= a_neg_c;
        dz_q      <= (b_i == '0);
      end else if (run_q) begin
        prem_q <= prem_nxt_c;
        pquo_q <= pquo_nxt_c;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (last_c) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
          quo_q  <= quo_fix_c;
          rem_q  <= rem_fix_c;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/multdiv_hilo_ctrl.sv
// Execute-stage controller for MULT/MULTU/DIV/DIVU and the HI/LO register pair.
module multdiv_hilo_ctrl
  import multdiv_hilo_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  decoded_op_t op_i,
  input  word_t       srca_i,
  input  word_t       srcb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output word_t       hi_o,
  output word_t       lo_o
);

  multdiv_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            hilo_q, hilo_d;
  logic             is_mul_q, is_mul_d;

  logic             stall_c;
  logic             mul_start_c;
  logic             div_start_c;
  logic             mul_signed_c;

  logic [63:0]                   mcand_q;
  logic [63:0]                   mplier_q;
  logic [63:0]                   prod_c;
  logic [MULT_LATENCY-1:0][63:0] pipe_q;

  logic             div_done;
  word_t            div_quo;
  word_t            div_rem;

  multdiv_hilo_ctrl_div_radix2 u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (div_start_c),
    .a_i      (srca_i),
    .b_i      (srcb_i),
    .signed_i (op_i == OP_DIV),
    .done_o   (div_done),
    .quo_o    (div_quo),
    .rem_o    (div_rem)
  );

  // Operands are pre-extended to 64 bits so one wrap-around multiply serves both signednesses.
  assign mul_signed_c = (op_i == OP_MULT);
  assign prod_c       = mcand_q * mplier_q;

  // Next-state, counter, HI/LO update and stall decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hilo_d      = hilo_q;
    is_mul_d    = is_mul_q;
    stall_c     = 1'b0;
    mul_start_c = 1'b0;
    div_start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              stall_c     = 1'b1;
              mul_start_c = 1'b1;
              is_mul_d    = 1'b1;
              cnt_d       = '0;
              state_d     = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              stall_c     = 1'b1;
              div_start_c = 1'b1;
              is_mul_d    = 1'b0;
              cnt_d       = '0;
              state_d     = S_DIV;
            end
            OP_MTHI: hilo_d.hi = srca_i;
            OP_MTLO: hilo_d.lo = srca_i;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MULT_LATENCY - 1)) state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (!flush_i) begin
          if (is_mul_q) begin
            hilo_d = pipe_q[MULT_LATENCY-1];
          end else if (div_done) begin
            hilo_d.hi = div_rem;
            hilo_d.lo = div_quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, counter and committed HI/LO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hilo_q   <= '0;
      is_mul_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hilo_q   <= hilo_d;
      is_mul_q <= is_mul_d;
    end
  end

  // Multiplier operand capture with signedness applied as extension.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (mul_start_c) begin
      mcand_q  <= {{32{mul_signed_c & srca_i[WORD_W-1]}}, srca_i};
      mplier_q <= {{32{mul_signed_c & srcb_i[WORD_W-1]}}, srcb_i};
    end
  end

  // Product register stages behind the inferred multiplier.
  if (MULT_LATENCY == 1) begin : g_pipe_one
    always_ff @(posedge clk) begin
      if (!resetn) pipe_q <= '0;
      else         pipe_q <= prod_c;
    end
  end else begin : g_pipe_many
    always_ff @(posedge clk) begin
      if (!resetn) pipe_q <= '0;
      else         pipe_q <= {pipe_q[MULT_LATENCY-2:0], prod_c};
    end
  end

  assign stall_o = stall_c;
  assign busy_o  = (state_q != S_IDLE);
  assign hi_o    = hilo_q.hi;
  assign lo_o    = hilo_q.lo;

endmodule

// File: tb/tb_multdiv_hilo_ctrl.sv
// Directed bench for multdiv_hilo_ctrl: latency, arithmetic corners, flush, reset and back-to-back ops.
module tb_multdiv_hilo_ctrl;
  import multdiv_hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  decoded_op_t op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multdiv_hilo_ctrl #(.MULT_LATENCY(3)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (valid),
    .op_i    (op),
    .srca_i  (srca),
    .srcb_i  (srcb),
    .flush_i (flush),
    .stall_o (stall),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Present one op, hold it while stalled, let the non-stalled edge commit, then drop valid.
  task automatic run_op(input decoded_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    valid = 1'b1; op = o; srca = a; srcb = b;
    #1;
    stalls = 0;
    while (stall && stalls < 200) begin
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid = 1'b0; op = OP_NOP;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; flush = 1'b0; op = OP_NOP; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, n);
    total++; if (n !== 4) begin bad++; $display("FAIL mult_latency got=%0d exp=4", n); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_neg_lo got=%h exp=fffffff1", lo); end
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL mult_m1m1_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h1) begin bad++; $display("FAIL mult_m1m1_lo got=%h exp=1", lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=1", lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(OP_DIVU, 32'd100, 32'd7, n);
    total++; if (n !== 33) begin bad++; $display("FAIL div_latency got=%0d exp=33", n); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=e", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=2", hi); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negb_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'h1) begin bad++; $display("FAIL div_negb_hi got=%h exp=1", hi); end
    run_op(OP_DIV, 32'd8, 32'd0, n);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'd8) begin bad++; $display("FAIL div_zero_hi got=%h exp=8", hi); end
    run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, n);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero_neg_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFF8) begin bad++; $display("FAIL div_zero_neg_hi got=%h exp=fffffff8", hi); end
    run_op(OP_DIVU, 32'hFFFF_FFF0, 32'd0, n);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFF0) begin bad++; $display("FAIL divu_zero_hi got=%h exp=fffffff0", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, n);
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL divu_big_lo got=%h exp=0", lo); end
    total++; if (hi !== 32'h8000_0000) begin bad++; $display("FAIL divu_big_hi got=%h exp=80000000", hi); end
  endtask

  task automatic test_mthi_then_mult();
    int n;
    run_op(OP_MTHI, 32'd1234, 32'd0, n);
    total++; if (n !== 0) begin bad++; $display("FAIL mthi_stall got=%0d exp=0", n); end
    total++; if (hi !== 32'd1234) begin bad++; $display("FAIL mthi_hi got=%h exp=4d2", hi); end
    run_op(OP_MULT, 32'd6, 32'd7, n);
    total++; if (n !== 4) begin bad++; $display("FAIL mthi_mult_latency got=%0d exp=4", n); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL mthi_mult_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL mthi_mult_lo got=%h exp=2a", lo); end
  endtask

  task automatic test_flush_div();
    int n;
    run_op(OP_MTHI, 32'hAAAA_AAAA, 32'd0, n);
    run_op(OP_MTLO, 32'hAAAA_AAAA, 32'd0, n);
    total++; if (lo !== 32'hAAAA_AAAA) begin bad++; $display("FAIL mtlo_lo got=%h exp=aaaaaaaa", lo); end
    valid = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL flushdiv_start_stall got=%b exp=1", stall); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flushdiv_busy got=%b exp=1", busy); end
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flushdiv_same_cycle_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0; op = OP_NOP;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flushdiv_idle got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flushdiv_stall got=%b exp=0", stall); end
    total++; if (hi !== 32'hAAAA_AAAA) begin bad++; $display("FAIL flushdiv_hi got=%h exp=aaaaaaaa", hi); end
    total++; if (lo !== 32'hAAAA_AAAA) begin bad++; $display("FAIL flushdiv_lo got=%h exp=aaaaaaaa", lo); end
    repeat (40) @(posedge clk);
    #1;
    total++; if ({hi, lo} !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL flushdiv_late got=%h exp=aaaaaaaaaaaaaaaa", {hi, lo}); end
  endtask

  task automatic test_flush_idle_done();
    int n;
    valid = 1'b1; op = OP_MTHI; srca = 32'd5; flush = 1'b1;
    #1;
    @(posedge clk); #1;
    total++; if (hi !== 32'hAAAA_AAAA) begin bad++; $display("FAIL flush_idle_mthi got=%h exp=aaaaaaaa", hi); end
    op = OP_MULT; srca = 32'd3; srcb = 32'd3;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    flush = 1'b0;
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL flush_done_latency got=%0d exp=4", n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_done_busy got=%b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0; op = OP_NOP;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_done_idle got=%b exp=0", busy); end
    total++; if (lo !== 32'hAAAA_AAAA) begin bad++; $display("FAIL flush_done_lo got=%h exp=aaaaaaaa", lo); end
  endtask

  task automatic test_reset_mid_mul();
    int n;
    valid = 1'b1; op = OP_MULT; srca = 32'd2; srcb = 32'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmul_busy got=%b exp=1", busy); end
    resetn = 1'b0; valid = 1'b0; op = OP_NOP;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmul_idle got=%b exp=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmul_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL rstmul_lo got=%h exp=0", lo); end
    resetn = 1'b1;
    run_op(OP_MULT, 32'd2, 32'd3, n);
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL rstmul_recover_lo got=%h exp=6", lo); end
  endtask

  task automatic test_back_to_back();
    int n1, n2, t0;
    t0 = cyc;
    run_op(OP_DIVU, 32'd100, 32'd7, n1);
    total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL b2b_first got=%h exp=000000020000000e", {hi, lo}); end
    run_op(OP_DIVU, 32'd1000, 32'd10, n2);
    total++; if (n1 !== 33 || n2 !== 33) begin bad++; $display("FAIL b2b_latency got=%0d,%0d exp=33,33", n1, n2); end
    total++; if (cyc - t0 !== 68) begin bad++; $display("FAIL b2b_cycles got=%0d exp=68", cyc - t0); end
    total++; if ({hi, lo} !== {32'd0, 32'd100}) begin bad++; $display("FAIL b2b_second got=%h exp=0000000000000064", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_then_mult();
    test_flush_div();
    test_flush_idle_done();
    test_reset_mid_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
